// File: rtl/instr_pkg.sv
// instr_pkg: mnemonic codes and MIPS opcode/function constants shared by the
// instruction encoder and the control decoder.
//   mnem_e      - 5-bit mnemonic code, 0..23 legal, 24..31 illegal
//   OP_* / FN_* - primary opcode and R-type function field values
//   mnem_legal  - true for codes that map to an instruction
package instr_pkg;

  typedef enum logic [4:0] {
    M_SLLV  = 5'd0,
    M_SRLV  = 5'd1,
    M_SRAV  = 5'd2,
    M_JR    = 5'd3,
    M_ADD   = 5'd4,
    M_ADDU  = 5'd5,
    M_SUB   = 5'd6,
    M_SUBU  = 5'd7,
    M_AND   = 5'd8,
    M_OR    = 5'd9,
    M_XOR   = 5'd10,
    M_NOR   = 5'd11,
    M_J     = 5'd12,
    M_BEQ   = 5'd13,
    M_BNE   = 5'd14,
    M_BLEZ  = 5'd15,
    M_BGTZ  = 5'd16,
    M_ADDI  = 5'd17,
    M_ADDIU = 5'd18,
    M_ANDI  = 5'd19,
    M_ORI   = 5'd20,
    M_XORI  = 5'd21,
    M_LW    = 5'd22,
    M_SW    = 5'd23
  } mnem_e;

  localparam logic [4:0] MNEM_LAST = 5'd23;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  function automatic logic mnem_legal(input logic [4:0] m);
    return m <= MNEM_LAST;
  endfunction

endpackage

// File: rtl/instr_encode_comb.sv
// instr_encode_comb: purely combinational MIPS word encoder.
//   mnem           in  5   mnemonic code (instr_pkg::mnem_e)
//   rs, rt, rd     in  5   register fields
//   imm            in  16  immediate / branch offset
//   target         in  26  jump index
//   word           out 32  encoded instruction (0 for illegal codes)
module instr_encode_comb
  import instr_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word
);

  function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d, input logic [5:0] f);
    return {OP_SPECIAL, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] k);
    return {op, s, t, k};
  endfunction

  always_comb begin
    word = '0;
    case (mnem_e'(mnem))
      M_SLLV:  word = r_type(rs, rt, rd, FN_SLLV);
      M_SRLV:  word = r_type(rs, rt, rd, FN_SRLV);
      M_SRAV:  word = r_type(rs, rt, rd, FN_SRAV);
      M_JR:    word = r_type(rs, 5'd0, 5'd0, FN_JR);
      M_ADD:   word = r_type(rs, rt, rd, FN_ADD);
      M_ADDU:  word = r_type(rs, rt, rd, FN_ADDU);
      M_SUB:   word = r_type(rs, rt, rd, FN_SUB);
      M_SUBU:  word = r_type(rs, rt, rd, FN_SUBU);
      M_AND:   word = r_type(rs, rt, rd, FN_AND);
      M_OR:    word = r_type(rs, rt, rd, FN_OR);
      M_XOR:   word = r_type(rs, rt, rd, FN_XOR);
      M_NOR:   word = r_type(rs, rt, rd, FN_NOR);
      M_J:     word = {OP_J, target};
      M_BEQ:   word = i_type(OP_BEQ, rs, rt, imm);
      M_BNE:   word = i_type(OP_BNE, rs, rt, imm);
      M_BLEZ:  word = i_type(OP_BLEZ, rs, 5'd0, imm);
      M_BGTZ:  word = i_type(OP_BGTZ, rs, 5'd0, imm);
      M_ADDI:  word = i_type(OP_ADDI, rs, rt, imm);
      M_ADDIU: word = i_type(OP_ADDIU, rs, rt, imm);
      M_ANDI:  word = i_type(OP_ANDI, rs, rt, imm);
      M_ORI:   word = i_type(OP_ORI, rs, rt, imm);
      M_XORI:  word = i_type(OP_XORI, rs, rt, imm);
      M_LW:    word = i_type(OP_LW, rs, rt, imm);
      M_SW:    word = i_type(OP_SW, rs, rt, imm);
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage instruction encoder pipeline with valid/ready
// handshakes, byte-address counter and saturating word counter.
//   clock, reset          rising-edge clock, async active-high reset
//   in_valid/in_ready     request handshake; mnem, rs, rt, rd, imm, target
//   out_valid/out_ready   result handshake; out_word, out_addr
//   base_load, base_addr  reload the address counter (word aligned)
//   err                   sticky flag: an illegal mnemonic was accepted
//   out_count             handshaken words, saturating at 0xFFFF
module instr_encoder
  import instr_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  input  logic        base_load,
  input  logic [31:0] base_addr,
  output logic        err,
  output logic [15:0] out_count
);

  logic        s1_valid;
  logic        s2_valid;
  logic [4:0]  s1_mnem;
  logic [4:0]  s1_rs;
  logic [4:0]  s1_rt;
  logic [4:0]  s1_rd;
  logic [15:0] s1_imm;
  logic [25:0] s1_target;
  logic [31:0] enc_word;
  logic [31:0] addr_cnt;
  logic        s2_en;
  logic        accept;
  logic        handshake;
  logic        in_legal;
  logic        unused_base_lsb;

  instr_encode_comb u_encode (
    .mnem   (s1_mnem),
    .rs     (s1_rs),
    .rt     (s1_rt),
    .rd     (s1_rd),
    .imm    (s1_imm),
    .target (s1_target),
    .word   (enc_word)
  );

  // S2 may load whenever its current word leaves (or it is empty); S1 may
  // load whenever it is empty or its content moves into S2.
  assign s2_en     = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign handshake = s2_valid && out_ready;
  assign in_legal  = mnem_legal(mnem);

  assign out_valid = s2_valid;
  assign out_addr  = addr_cnt;

  assign unused_base_lsb = ^base_addr[1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_mnem   <= '0;
      s1_rs     <= '0;
      s1_rt     <= '0;
      s1_rd     <= '0;
      s1_imm    <= '0;
      s1_target <= '0;
      out_word  <= '0;
      err       <= 1'b0;
      addr_cnt  <= '0;
      out_count <= '0;
    end else begin
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) out_word <= enc_word;
      end
      // Illegal codes are consumed here but never marked valid in S1.
      if (in_ready) s1_valid <= in_valid && in_legal;
      if (accept) begin
        s1_mnem   <= mnem;
        s1_rs     <= rs;
        s1_rt     <= rt;
        s1_rd     <= rd;
        s1_imm    <= imm;
        s1_target <= target;
        if (!in_legal) err <= 1'b1;
      end
      // A reload takes priority; the departing word already showed the old address.
      if (base_load)      addr_cnt <= {base_addr[31:2], 2'b00};
      else if (handshake) addr_cnt <= addr_cnt + 32'd4;
      if (handshake && out_count != 16'hFFFF) out_count <= out_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  mnem = '0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic [4:0]  rd = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        base_load = 1'b0;
  logic [31:0] base_addr = '0;
  logic        err;
  logic [15:0] out_count;

  instr_encoder dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mnem      (mnem),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .imm       (imm),
    .target    (target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_addr  (out_addr),
    .base_load (base_load),
    .base_addr (base_addr),
    .err       (err),
    .out_count (out_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Encoding tables written straight from the instruction set definition.
  localparam logic [5:0] FN_TAB [12] = '{6'b000100, 6'b000110, 6'b000111, 6'b001000,
                                         6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                         6'b100100, 6'b100101, 6'b100110, 6'b100111};
  localparam logic [5:0] OP_TAB [11] = '{6'b000100, 6'b000101, 6'b000110, 6'b000111,
                                         6'b001000, 6'b001001, 6'b001100, 6'b001101,
                                         6'b001110, 6'b100011, 6'b101011};

  function automatic logic [31:0] ref_word(input logic [4:0] m, input logic [4:0] s,
                                           input logic [4:0] t, input logic [4:0] d,
                                           input logic [15:0] k, input logic [25:0] tg);
    int idx = int'(m);
    if (idx < 12) begin
      if (idx == 3) return {6'd0, s, 5'd0, 5'd0, 5'd0, FN_TAB[idx]};
      return {6'd0, s, t, d, 5'd0, FN_TAB[idx]};
    end
    if (idx == 12) return {6'b000010, tg};
    if (idx == 15 || idx == 16) return {OP_TAB[idx-13], s, 5'd0, k};
    return {OP_TAB[idx-13], s, t, k};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Reference model, evaluated between edges.
  logic [31:0] exp_q[$];
  logic [31:0] hs_word[$];
  logic [31:0] hs_addr[$];
  logic [31:0] m_addr = '0;
  int          m_cnt = 0;
  logic        m_err = 1'b0;
  int          n_acc = 0;
  int          n_hs = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_word = '0;

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_addr = '0;
      m_cnt = 0;
      m_err = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check("addr_counter", out_addr, m_addr);
      check("out_count", {16'd0, out_count}, (m_cnt > 65535) ? 32'hFFFF : 32'(m_cnt));
      check("err_flag", {31'd0, err}, {31'd0, m_err});
      if (stall_prev) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_word", out_word, stall_word);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("extra_word");
        else check("word", out_word, exp_q.pop_front());
        hs_word.push_back(out_word);
        hs_addr.push_back(out_addr);
        n_hs++;
        m_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      stall_word = out_word;
      if (base_load) m_addr = {base_addr[31:2], 2'b00};
      else if (out_valid && out_ready) m_addr = m_addr + 32'd4;
      if (in_valid && in_ready) begin
        n_acc++;
        if (mnem <= 5'd23) exp_q.push_back(ref_word(mnem, rs, rt, rd, imm, target));
        else m_err = 1'b1;
      end
    end
  end

  // Callers stand 1 time unit after a rising edge.
  task automatic drive(input logic [4:0] m, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [15:0] k, input logic [25:0] tg);
    in_valid = 1'b1;
    mnem = m; rs = s; rt = t; rd = d; imm = k; target = tg;
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock); #1;
        in_valid = 1'b0;
        return;
      end
    end
    fail_now("accept_timeout");
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [4:0] m, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [15:0] k, input logic [25:0] tg);
    drive(m, s, t, d, k, tg);
    wait_accept();
  endtask

  task automatic wait_hs(input int n);
    for (int i = 0; i < 200; i++) begin
      if (n_hs >= n) return;
      @(posedge clock); #1;
    end
    fail_now("handshake_timeout");
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  int base;
  int acc0;

  initial begin
    // Reset values.
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_word", out_word, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_out_count", {16'd0, out_count}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // ADD and the reference encodings.
    out_ready = 1'b1;
    base = n_hs;
    send(5'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    wait_hs(base + 1);
    check("add_word", hs_word[base], 32'h00221820);
    check("add_addr", hs_addr[base], 32'h0);
    @(negedge clock);
    check("add_count", {16'd0, out_count}, 32'd1);
    @(posedge clock); #1;
    send(5'd22, 5'd29, 5'd8, 5'd0, 16'h0010, 26'h0);
    send(5'd12, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
    send(5'd15, 5'd4, 5'd7, 5'd0, 16'hFFFE, 26'h0);
    wait_hs(base + 4);
    check("lw_word", hs_word[base+1], 32'h8FA80010);
    check("j_word", hs_word[base+2], 32'h08100000);
    check("blez_word", hs_word[base+3], 32'h1880FFFE);

    // Back-pressure: two accepted, third held off, then all three drain in order.
    do_reset();
    out_ready = 1'b0;
    base = n_hs;
    acc0 = n_acc;
    send(5'd5, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
    send(5'd9, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0);
    drive(5'd20, 5'd3, 5'd3, 5'd0, 16'h1234, 26'h0);
    repeat (3) @(negedge clock);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_accepted", 32'(n_acc - acc0), 32'd2);
    @(posedge clock); #1;
    out_ready = 1'b1;
    wait_accept();
    wait_hs(base + 3);
    check("bp_w0", hs_word[base], ref_word(5'd5, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0));
    check("bp_w1", hs_word[base+1], ref_word(5'd9, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0));
    check("bp_w2", hs_word[base+2], 32'h34631234);
    check("bp_a0", hs_addr[base], 32'h0);
    check("bp_a1", hs_addr[base+1], 32'h4);
    check("bp_a2", hs_addr[base+2], 32'h8);

    // Illegal mnemonic between two legal ones.
    do_reset();
    base = n_hs;
    send(5'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    send(5'd25, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    send(5'd4, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
    wait_hs(base + 2);
    repeat (5) @(posedge clock);
    #1;
    check("ill_words", 32'(n_hs - base), 32'd2);
    check("ill_a0", hs_addr[base], 32'h0);
    check("ill_a1", hs_addr[base+1], 32'h4);
    check("ill_err", {31'd0, err}, 32'd1);

    // Counter load and wrap.
    base_load = 1'b1;
    base_addr = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    base_load = 1'b0;
    check("load_addr", out_addr, 32'hFFFF_FFFC);
    base = n_hs;
    send(5'd17, 5'd1, 5'd2, 5'd0, 16'h7FFF, 26'h0);
    send(5'd23, 5'd3, 5'd4, 5'd0, 16'h8000, 26'h0);
    wait_hs(base + 2);
    check("wrap_a0", hs_addr[base], 32'hFFFF_FFFC);
    check("wrap_a1", hs_addr[base+1], 32'h0);
    check("err_sticky", {31'd0, err}, 32'd1);

    // Load colliding with a handshake.
    out_ready = 1'b0;
    base = n_hs;
    send(5'd3, 5'd9, 5'd9, 5'd9, 16'h0, 26'h0);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clock); #1;
    end
    base_load = 1'b1;
    base_addr = 32'h0000_1003;
    out_ready = 1'b1;
    @(posedge clock); #1;
    base_load = 1'b0;
    wait_hs(base + 1);
    check("coll_addr", hs_addr[base], 32'h4);
    check("coll_word", hs_word[base], 32'h01200008);
    check("coll_new", out_addr, 32'h0000_1000);

    // Reset with both stages full.
    send(5'd30, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    out_ready = 1'b0;
    send(5'd6, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
    send(5'd7, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_err", {31'd0, err}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    base = n_hs;
    send(5'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    wait_hs(base + 1);
    check("post_rst_addr", hs_addr[base], 32'h0);
    check("post_rst_word", hs_word[base], 32'h00221820);
    check("post_rst_err", {31'd0, err}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      mnem = ($urandom_range(0, 15) == 0) ? 5'(24 + $urandom_range(0, 7)) : 5'($urandom_range(0, 23));
      rs = 5'($urandom);
      rt = 5'($urandom);
      rd = 5'($urandom);
      imm = 16'($urandom);
      target = 26'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      base_load = ($urandom_range(0, 31) == 0);
      base_addr = $urandom;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    base_load = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    // Count saturation under continuous traffic.
    do_reset();
    out_ready = 1'b1;
    drive(5'd8, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    repeat (65545) @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("sat_count", {16'd0, out_count}, 32'h0000_FFFF);
    check("sat_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
